pc_branch_unit: RTL

- Program-counter and branch stage directly downstream of the 8-bit ALU; consumes the ALU `overflow` flag and the executing `OPCODE`.
- Holds the architectural flag register, resolves BNO/BOF branches through a 16-entry branch-target LUT, and produces the fetch PC for the next instruction.
- Provides start/halt control for the core.

---
 rtl/pc_branch_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pc_branch_unit.sv
// PC / branch stage behind the 8-bit ALU: flag register, BNO/BOF resolution via a target LUT, run/halt.
// Optional BRANCH_CNT_EN adds a saturating taken-branch counter on branch_count.
module pc_branch_unit #(
   parameter int unsigned     PC_W      = 10,
   parameter logic [PC_W-1:0] START_PC  = '0,
   parameter int unsigned     LUT_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [5:0]      OPCODE,
   input  logic            overflow,
   input  logic [3:0]      branch_idx,
   input  logic            halt_req,
   input  logic            stall,
   input  logic            lut_we,
   input  logic [3:0]      lut_waddr,
   input  logic [PC_W-1:0] lut_wdata,
   output logic [PC_W-1:0] pc,
   output logic            pc_valid,
   output logic            flag,
   output logic            taken,
`ifdef BRANCH_CNT_EN
   output logic [15:0]     branch_count,
`endif
   output logic            done
);

   localparam logic [5:0] OpAdd   = 6'b010000;
   localparam logic [5:0] OpMatch = 6'b011000;
   localparam logic [5:0] OpLt    = 6'b100000;
   localparam logic [5:0] OpLsl   = 6'b110000;
   localparam logic [5:0] OpAnd1  = 6'b110011;
   localparam logic [5:0] OpEqz   = 6'b110100;
   localparam logic [5:0] OpBno   = 6'b111000;
   localparam logic [5:0] OpBof   = 6'b111001;

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            flag_q, flag_d;
   logic            taken_q, taken_d;
   logic [PC_W-1:0] lut_q [LUT_DEPTH];
   logic            flag_wr;
   logic            branch_hit;

`ifdef BRANCH_CNT_EN
   logic [15:0] cnt_q, cnt_d;
`endif

   always_comb begin
      flag_wr = 1'b0;
      unique case (OPCODE)
         OpAdd, OpMatch, OpLt, OpLsl, OpAnd1, OpEqz: flag_wr = 1'b1;
         default:                                    flag_wr = 1'b0;
      endcase
   end

   // Resolved against the flag before this cycle's update; branch opcodes never write it.
   assign branch_hit = ((OPCODE == OpBof) && flag_q) || ((OPCODE == OpBno) && !flag_q);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flag_d  = flag_q;
      taken_d = 1'b0;
`ifdef BRANCH_CNT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               pc_d    = START_PC;
               flag_d  = 1'b0;
`ifdef BRANCH_CNT_EN
               cnt_d   = '0;
`endif
            end
         end
         StRun: begin
            if (!stall) begin
               if (halt_req) begin
                  state_d = StHalt;
               end else begin
                  if (branch_hit) begin
                     pc_d    = lut_q[branch_idx];
                     taken_d = 1'b1;
`ifdef BRANCH_CNT_EN
                     if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
                  end else begin
                     pc_d = pc_q + PC_W'(1);
                  end
                  if (flag_wr) flag_d = overflow;
               end
            end
         end
         StHalt: begin
            if (start) begin
               state_d = StRun;
               pc_d    = START_PC;
               flag_d  = 1'b0;
`ifdef BRANCH_CNT_EN
               cnt_d   = '0;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= START_PC;
         flag_q  <= 1'b0;
         taken_q <= 1'b0;
`ifdef BRANCH_CNT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flag_q  <= flag_d;
         taken_q <= taken_d;
`ifdef BRANCH_CNT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Reads see the pre-write entry; a write becomes visible the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
      end else if (lut_we) begin
         lut_q[lut_waddr] <= lut_wdata;
      end
   end

   assign pc       = pc_q;
   assign flag     = flag_q;
   assign taken    = taken_q;
   assign pc_valid = (state_q == StRun);
   assign done     = (state_q == StHalt);
`ifdef BRANCH_CNT_EN
   assign branch_count = cnt_q;
`endif

endmodule
